// File: rtl/led_chase_sequencer.sv
// Shift-light run-time controller: emits step enable (SS) and direction (MODE) for
// left sweep / pause / right sweep / pause round trips. All outputs registered.
module led_chase_sequencer #(
  parameter int TICK_DIV    = 4,
  parameter int STEPS       = 8,
  parameter int PAUSE_TICKS = 3
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic [1:0] SPEED,
  input  logic [3:0] CYCLES,
  output logic       SS,
  output logic       MODE,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] STEP_CNT
);

  localparam int PW = $clog2(TICK_DIV * 8 + 1);
  localparam int CW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_PAUSE_L,
    S_RIGHT,
    S_PAUSE_R
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [PW-1:0] period;
  logic [1:0]    speed_q;
  logic [3:0]    cycles_q;
  logic [3:0]    trip_q;
  logic [3:0]    trip_d;
  logic [CW-1:0] pause_q;
  logic [3:0]    step_q;
  logic          ss_q;
  logic          mode_q;
  logic          busy_q;
  logic          done_q;
  logic          tick;
  logic          pre_tick;

  // SS is high during the tick cycle itself, so it is set one cycle early (pre_tick)
  // while state moves at the edge that closes the tick.
  always_comb begin
    period   = PW'(TICK_DIV) << speed_q;
    tick     = (presc_q == period - PW'(1));
    pre_tick = (presc_q == period - PW'(2));
    presc_d  = tick ? '0 : presc_q + PW'(1);
    trip_d   = trip_q + 4'd1;
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      speed_q  <= '0;
      cycles_q <= '0;
      trip_q   <= '0;
      pause_q  <= '0;
      step_q   <= '0;
      ss_q     <= 1'b0;
      mode_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ss_q   <= 1'b0;
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (START && !STOP) begin
          state_q  <= S_LEFT;
          busy_q   <= 1'b1;
          mode_q   <= 1'b1;
          speed_q  <= SPEED;
          cycles_q <= CYCLES;
          presc_q  <= '0;
          trip_q   <= '0;
          pause_q  <= '0;
          step_q   <= '0;
        end
      end else if (STOP) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        presc_q <= '0;
        trip_q  <= '0;
        pause_q <= '0;
        step_q  <= '0;
      end else begin
        presc_q <= presc_d;
        case (state_q)
          S_LEFT, S_RIGHT: begin
            if (pre_tick) begin
              ss_q   <= 1'b1;
              step_q <= step_q + 4'd1;
            end
            if (tick && step_q == 4'(STEPS)) begin
              state_q <= (state_q == S_LEFT) ? S_PAUSE_L : S_PAUSE_R;
              step_q  <= '0;
            end
          end
          S_PAUSE_L: begin
            if (tick) begin
              if (pause_q == CW'(PAUSE_TICKS - 1)) begin
                pause_q <= '0;
                state_q <= S_RIGHT;
                mode_q  <= 1'b0;
              end else begin
                pause_q <= pause_q + CW'(1);
              end
            end
          end
          S_PAUSE_R: begin
            if (tick) begin
              if (pause_q == CW'(PAUSE_TICKS - 1)) begin
                pause_q <= '0;
                trip_q  <= trip_d;
                // CYCLES=0 lets the trip counter wrap without ever terminating
                if (cycles_q != 4'd0 && trip_d == cycles_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  presc_q <= '0;
                  trip_q  <= '0;
                end else begin
                  state_q <= S_LEFT;
                  mode_q  <= 1'b1;
                end
              end else begin
                pause_q <= pause_q + CW'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign SS       = ss_q;
  assign MODE     = mode_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign STEP_CNT = step_q;

endmodule

// File: tb/tb_led_chase_sequencer.sv
// Bench for led_chase_sequencer: table of runs plus hand sequences, SS pulses scored
// against a queue of predicted {cycle, mode, step, led} records.
module tb_led_chase_sequencer;

  logic       Clk = 1'b0;
  logic       RST;
  logic       START;
  logic       STOP;
  logic [1:0] SPEED;
  logic [3:0] CYCLES;
  logic       SS;
  logic       MODE;
  logic       BUSY;
  logic       DONE;
  logic [3:0] STEP_CNT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic       mode;
    logic [3:0] step;
    logic [7:0] led;
  } exp_t;

  typedef struct {
    logic [1:0] speed;
    logic [3:0] cycles;
    int         trips;
    int         stop_after;
    bit         chg;
    int         exp_pulses;
    int         exp_done;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vt[6];
  int         exp_done = -1;
  int         pulses_seen = 0;
  int         done_seen = 0;
  logic [7:0] led_m = 8'd0;

  led_chase_sequencer dut (
    .Clk      (Clk),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .SPEED    (SPEED),
    .CYCLES   (CYCLES),
    .SS       (SS),
    .MODE     (MODE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .STEP_CNT (STEP_CNT)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predicted SS pulses: edge e0 accepts START; pulse k of a left sweep is seen in
  // cycle e0+k*P-1, right sweep starts 11 ticks in, round trip is 22 ticks.
  task automatic push_trips(input int e0, input int p, input int trips, input int limit);
    exp_t e;
    int   n;
    int   base;
    n = 0;
    for (int t = 0; t < trips; t++) begin
      base = e0 + t * 22 * p;
      for (int k = 1; k <= 16; k++) begin
        if (n < limit) begin
          if (k <= 8) begin
            e.cyc  = base + k * p - 1;
            e.mode = 1'b1;
            e.step = 4'(k);
            e.led  = 8'(1 << (k - 1));
          end else begin
            e.cyc  = base + (3 + k) * p - 1;
            e.mode = 1'b0;
            e.step = 4'(k - 8);
            e.led  = 8'(128 >> (k - 8));
          end
          sb.push_back(e);
          n++;
        end
      end
    end
  endtask

  // Monitor: pops one record per SS pulse; LED is a shifter model fed by SS/MODE.
  always @(negedge Clk) begin
    if (!RST) begin
      if (SS) begin
        pulses_seen++;
        led_m = MODE ? ((led_m == 8'd0) ? 8'd1 : {led_m[6:0], 1'b0}) : {1'b0, led_m[7:1]};
        if (sb.size() == 0) begin
          check("unexpected_ss", cyc, -1);
        end else begin
          mon_e = sb.pop_front();
          check("ss_cycle", cyc, mon_e.cyc);
          check("ss_mode", MODE, mon_e.mode);
          check("step_cnt", STEP_CNT, mon_e.step);
          check("led", led_m, mon_e.led);
        end
      end
      if (DONE) begin
        done_seen++;
        check("done_cycle", cyc, exp_done);
        check("busy_with_done", BUSY, 0);
      end
    end
  end

  task automatic start_run(input logic [1:0] spd, input logic [3:0] cyc_n, input int trips,
                           input int limit, input int done_ofs, output int e0);
    @(negedge Clk);
    SPEED  = spd;
    CYCLES = cyc_n;
    START  = 1'b1;
    e0 = cyc + 1;
    pulses_seen = 0;
    done_seen   = 0;
    led_m       = 8'd0;
    sb.delete();
    push_trips(e0, 4 << spd, trips, limit);
    exp_done = (done_ofs < 0) ? -1 : e0 + done_ofs;
    @(negedge Clk);
    START = 1'b0;
    check("busy_after_start", BUSY, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int e0;
    int p;
    int waited;
    p = 4 << v.speed;
    start_run(v.speed, v.cycles, v.trips, v.exp_pulses, v.exp_done, e0);
    if (v.chg) begin
      SPEED  = ~v.speed;
      CYCLES = 4'hF;
    end
    waited = 0;
    if (v.stop_after > 0) begin
      while (pulses_seen < v.stop_after && waited < v.stop_after * p + 10) begin
        @(negedge Clk);
        waited++;
      end
      STOP = 1'b1;
      @(negedge Clk);
      STOP = 1'b0;
      check("busy_after_stop", BUSY, 0);
      check("stepcnt_after_stop", STEP_CNT, 0);
      repeat (3 * p) @(negedge Clk);
    end else begin
      while (done_seen == 0 && waited < v.exp_done + 20) begin
        @(negedge Clk);
        waited++;
      end
    end
    check("pulse_count", pulses_seen, v.exp_pulses);
    check("done_count", done_seen, (v.exp_done >= 0) ? 1 : 0);
    check("sb_empty", sb.size(), 0);
    check("busy_at_end", BUSY, 0);
  endtask

  initial begin
    int e0;
    int waited;
    int n;

    RST = 1'b1; START = 1'b0; STOP = 1'b0; SPEED = 2'd0; CYCLES = 4'd0;
    #2;
    check("rst_ss", SS, 0);
    check("rst_mode", MODE, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_stepcnt", STEP_CNT, 0);
    repeat (3) @(negedge Clk);
    RST = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_busy", BUSY, 0);

    // speed, cycles, trips, stop_after, change inputs mid-run, pulses, done offset
    vt[0] = '{2'd0, 4'd1, 1, 0, 1'b0, 16, 88};
    vt[1] = '{2'd2, 4'd2, 2, 0, 1'b1, 32, 704};
    vt[2] = '{2'd1, 4'd1, 1, 0, 1'b1, 16, 176};
    vt[3] = '{2'd0, 4'd3, 3, 0, 1'b0, 48, 264};
    vt[4] = '{2'd0, 4'd1, 1, 3, 1'b0, 3,  -1};
    vt[5] = '{2'd3, 4'd1, 1, 0, 1'b0, 16, 704};
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // START together with STOP in IDLE stays idle
    @(negedge Clk);
    n = pulses_seen;
    START = 1'b1; STOP = 1'b1;
    @(negedge Clk);
    START = 1'b0; STOP = 1'b0;
    check("start_stop_busy", BUSY, 0);
    repeat (12) @(negedge Clk);
    check("start_stop_no_ss", pulses_seen, n);

    // Continuous run with ignored START pulses, then STOP after 4 round trips
    start_run(2'd0, 4'd0, 4, 64, -1, e0);
    waited = 0;
    while (pulses_seen < 64 && waited < 400) begin
      @(negedge Clk);
      waited++;
      START = (waited == 20 || waited == 100 || waited == 200);
      if (waited == 40) check("stepcnt_in_pause", STEP_CNT, 0);
    end
    START = 1'b0;
    STOP  = 1'b1;
    @(negedge Clk);
    STOP = 1'b0;
    check("cont_busy_after_stop", BUSY, 0);
    repeat (10) @(negedge Clk);
    check("cont_pulses", pulses_seen, 64);
    check("cont_no_done", done_seen, 0);
    check("cont_sb_empty", sb.size(), 0);

    // Asynchronous reset while SS is high mid-LEFT
    start_run(2'd0, 4'd1, 1, 16, 88, e0);
    waited = 0;
    while (!(SS === 1'b1 && STEP_CNT == 4'd2) && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    check("reached_step2", STEP_CNT, 2);
    #2;
    RST = 1'b1;
    #1;
    check("arst_ss", SS, 0);
    check("arst_mode", MODE, 1);
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_stepcnt", STEP_CNT, 0);
    sb.delete();
    exp_done = -1;
    repeat (3) @(negedge Clk);
    RST = 1'b0;
    n = pulses_seen;
    repeat (40) @(negedge Clk);
    check("post_rst_no_ss", pulses_seen, n);
    check("post_rst_busy", BUSY, 0);
    check("post_rst_no_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_chase_sequencer.md
# led_chase_sequencer

Run-time controller for the 8-LED shift-light datapath. It generates the one-cycle step enable (SS) and direction (MODE) that drive the shifter. One round trip is a left sweep, a pause, a right sweep and a second pause. The round trip repeats a programmed number of times or runs until stopped. The block sits between the board buttons/config switches and the shifter, and owns all step timing.

## Interface
- TICK_DIV, 4: base number of Clk cycles per step tick (≥2).
- STEPS, 8: shift steps per sweep.
- PAUSE_TICKS, 3: idle ticks after each sweep.
- Clk  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  begin sequence; level sampled each Clk edge, acted on only in IDLE.
- STOP  in  1  abort sequence; acted on in any non-IDLE state.
- SPEED  in  2  tick period multiplier; period P = TICK_DIV << SPEED; latched when START is accepted.
- CYCLES  in  4  round trips to run, 0 = run forever; latched when START is accepted.
- SS  out  1  shifter step enable; one-cycle pulse per step.
- MODE  out  1  shifter direction: 1 = left (LSB→MSB), 0 = right.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- STEP_CNT  out  4  steps issued in the current sweep, 0..STEPS.

## Operation
- All outputs are registered. Reset values: SS=0, MODE=1, BUSY=0, DONE=0, STEP_CNT=0. The state is IDLE, and the prescaler and round-trip counter are 0.
- Prescaler counts 0..P-1 and wraps. A tick is the cycle in which the prescaler equals P-1. The prescaler is cleared when START is accepted and free-runs while BUSY.
- States:
  - IDLE: SS=0, BUSY=0. START=1 moves to LEFT and latches SPEED and CYCLES.
  - LEFT: MODE=1. Each tick asserts SS for that cycle and increments STEP_CNT. The tick that issues step STEPS moves to PAUSE_L, and STEP_CNT clears on entry to PAUSE_L.
  - PAUSE_L: SS=0, MODE holds 1. After PAUSE_TICKS ticks, moves to RIGHT.
  - RIGHT: same as LEFT but with MODE=0. Moves to PAUSE_R.
  - PAUSE_R: after PAUSE_TICKS ticks, increments the round-trip counter. If CYCLES≠0 and the count equals CYCLES, moves to IDLE with DONE=1 for one cycle. Otherwise moves to LEFT.
- STOP=1 in any non-IDLE state forces IDLE at the next edge. There is no DONE pulse, and SS is 0 from that edge on. STEP_CNT and the counters clear. MODE keeps its last value.
- START and STOP in the same cycle: STOP wins. From IDLE the block stays in IDLE.
- START while BUSY is ignored. SPEED and CYCLES changes while BUSY are ignored.
- The round-trip counter is 4 bits. With CYCLES=0 it wraps freely and never terminates the run.
- RST mid-run returns to the reset values immediately, with no DONE pulse.

## Timing
- START sampled at edge E0 → BUSY=1 and state LEFT from E0.
- First SS is high in the cycle after edge E0+P-1, i.e. the shifter moves at edge E0+P. Later SS pulses come every P cycles.
- Sweep = STEPS·P cycles and pause = PAUSE_TICKS·P cycles. One round trip = (2·STEPS+2·PAUSE_TICKS)·P = 88 cycles at the defaults with SPEED=0.
- DONE rises at the same edge where BUSY falls. The block can accept the next START on the following edge.
- With the shifter attached and starting from LED=0, one round trip at the defaults gives:
  - left sweep: 01,02,04,08,10,20,40,80
  - right sweep: 40,20,10,08,04,02,01,00
- MODE changes only at sweep boundaries. It never changes in the same cycle as an SS pulse.

## Test plan
- Reset: assert RST asynchronously mid-LEFT → SS=0, MODE=1, BUSY=0, DONE=0 and STEP_CNT=0 without waiting for a clock edge. After release, the block stays in IDLE with no SS.
- Single trip: SPEED=0, CYCLES=1, START pulse → exactly 16 SS pulses, 4 cycles apart. MODE=1 for pulses 1–8 and 0 for pulses 9–16. DONE pulses once 88 cycles after START, and BUSY drops with it. The LED sequence is as listed under Timing.
- Speed: SPEED=2, CYCLES=2 → SS spacing is 16 cycles, there are 32 SS pulses, and DONE arrives 704 cycles after START. Changing SPEED mid-run has no effect.
- Abort: STOP after the 3rd SS pulse in LEFT → IDLE next edge, no further SS, DONE stays 0. START and STOP asserted together in IDLE → BUSY stays 0.
- Continuous: CYCLES=0 for 4 round trips → no DONE and STEP_CNT cycles 1..8. START pulses during the run are ignored, and the prescaler phase does not shift.
